// File: rtl/seq_div8_core_pkg.sv
// Shared arithmetic-unit header: FSM state encoding and sign/magnitude helpers
// used by the sequential divider (and its multiplier sibling).
package seq_div8_core_pkg;

  localparam int unsigned MAX_W = 64;

  typedef logic [MAX_W-1:0] wide_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Conditional two's-complement negate of a w-bit value held in a wide word.
  // Callers keep only the low w bits, so the most negative value maps onto
  // its own bit pattern, which is exactly its unsigned magnitude.
  function automatic wide_t f_abs_mag(input wide_t val, input int unsigned w, input logic sgn);
    logic neg;
    neg = sgn & val[w-1];
    return neg ? (~val + wide_t'(1)) : val;
  endfunction

  function automatic wide_t f_apply_sign(input wide_t mag, input logic neg);
    return neg ? (~mag + wide_t'(1)) : mag;
  endfunction

endpackage

// File: rtl/seq_div8_core_restore_step.sv
// One radix-2 restoring division step: shift the remainder/dividend pair left,
// trial-subtract the divisor and keep the difference when no borrow occurs.
module div_restore_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] sr,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] sr_next,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  // The partial remainder never reaches 2^WIDTH, so the top bit of the shifted
  // value is always 0 and the top bit of the difference is the borrow.
  always_comb begin
    shifted  = {rem, sr[WIDTH-1]};
    diff     = shifted - (WIDTH+2)'(dvs);
    q_bit    = ~diff[WIDTH+1];
    rem_next = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
    sr_next  = {sr[WIDTH-2:0], q_bit};
  end

endmodule

// File: rtl/seq_div8_core.sv
// Iterative restoring divider with per-operand signedness; WIDTH steps in CALC,
// one sign-fixup cycle in FIX, then a single-cycle done pulse.
module seq_div8_core
  import seq_div8_core_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic [1:0]       sign_mode,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_t state, next_state;

  logic [WIDTH:0]     rem_q;
  logic [WIDTH-1:0]   sr_q;
  logic [WIDTH-1:0]   dvs_q;
  logic [WIDTH-1:0]   a_orig_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               neg_a_q;
  logic               neg_b_q;
  logic               zero_div_q;

  logic [WIDTH:0]     rem_nx;
  logic [WIDTH-1:0]   sr_nx;
  logic               q_bit_nx;

  wide_t a_abs_w, b_abs_w, q_sgn_w, r_sgn_w;
  logic  unused_hi;

  always_comb begin
    a_abs_w = f_abs_mag(wide_t'(dividend), WIDTH, sign_mode[1]);
    b_abs_w = f_abs_mag(wide_t'(divisor),  WIDTH, sign_mode[0]);
    q_sgn_w = f_apply_sign(wide_t'(sr_q), neg_a_q ^ neg_b_q);
    r_sgn_w = f_apply_sign(wide_t'(rem_q[WIDTH-1:0]), neg_a_q);
  end

  assign unused_hi = ^{a_abs_w[MAX_W-1:WIDTH], b_abs_w[MAX_W-1:WIDTH],
                       q_sgn_w[MAX_W-1:WIDTH], r_sgn_w[MAX_W-1:WIDTH], q_bit_nx};

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .sr       (sr_q),
    .dvs      (dvs_q),
    .rem_next (rem_nx),
    .sr_next  (sr_nx),
    .q_bit    (q_bit_nx)
  );

  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = CALC;
      CALC:    if (cnt_q == CNT_W'(1)) next_state = FIX;
      FIX:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      rem_q       <= '0;
      sr_q        <= '0;
      dvs_q       <= '0;
      a_orig_q    <= '0;
      cnt_q       <= '0;
      neg_a_q     <= 1'b0;
      neg_b_q     <= 1'b0;
      zero_div_q  <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      state <= next_state;
      done  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            rem_q      <= '0;
            sr_q       <= a_abs_w[WIDTH-1:0];
            dvs_q      <= b_abs_w[WIDTH-1:0];
            a_orig_q   <= dividend;
            neg_a_q    <= sign_mode[1] & dividend[WIDTH-1];
            neg_b_q    <= sign_mode[0] & divisor[WIDTH-1];
            zero_div_q <= (divisor == '0);
            cnt_q      <= CNT_W'(WIDTH);
          end
        end
        CALC: begin
          rem_q <= rem_nx;
          sr_q  <= sr_nx;
          cnt_q <= cnt_q - CNT_W'(1);
        end
        FIX: begin
          // A zero divisor reports all-ones and hands the dividend back untouched.
          quotient    <= zero_div_q ? '1 : q_sgn_w[WIDTH-1:0];
          remainder   <= zero_div_q ? a_orig_q : r_sgn_w[WIDTH-1:0];
          div_by_zero <= zero_div_q;
          done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div8_core.sv
// Directed self-checking bench for seq_div8_core (WIDTH=8): latency, signed
// modes, divide-by-zero, overflow, ignored start, back-to-back and reset.
module tb_seq_div8_core;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic [1:0] sign_mode;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int tests = 0;
  int fails = 0;

  seq_div8_core #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .sign_mode   (sign_mode),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Launches one division and returns at the negedge where done is seen.
  // edges counts rising edges from the accepting edge (inclusive).
  task automatic run_div(input logic [7:0] a, input logic [7:0] b, input logic [1:0] sm,
                         input bit at_current, output int edges, output int busy_cyc,
                         output bit timed_out);
    if (!at_current) @(negedge clk);
    dividend  = a;
    divisor   = b;
    sign_mode = sm;
    start     = 1'b1;
    @(posedge clk);
    edges     = 1;
    busy_cyc  = 0;
    timed_out = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        timed_out = 1'b0;
        break;
      end
      if (busy) busy_cyc++;
      @(posedge clk);
      edges++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0; sign_mode = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({quotient, remainder, busy, done, div_by_zero} !== 19'd0) begin
      fails++;
      $display("FAIL reset_outputs: got q=%h r=%h busy=%b done=%b dbz=%b, expected all 0",
               quotient, remainder, busy, done, div_by_zero);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned();
    int e, bc; bit to;
    run_div(8'd100, 8'd7, 2'b00, 1'b0, e, bc, to);
    tests++;
    if (to || e !== 10) begin
      fails++; $display("FAIL unsigned_latency: got %0d edges (timeout=%b), expected 10", e, to);
    end
    tests++;
    if (bc !== 9) begin
      fails++; $display("FAIL unsigned_busy: got %0d busy cycles, expected 9", bc);
    end
    tests++;
    if (quotient !== 8'h0E || remainder !== 8'h02 || div_by_zero !== 1'b0) begin
      fails++; $display("FAIL unsigned_100_7: got q=%h r=%h dbz=%b, expected q=0e r=02 dbz=0",
                        quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || quotient !== 8'h0E) begin
      fails++; $display("FAIL done_pulse_width: got done=%b q=%h, expected done=0 q=0e", done, quotient);
    end
  endtask

  task automatic test_signed();
    int e, bc; bit to;
    run_div(8'hF9, 8'h02, 2'b11, 1'b0, e, bc, to);
    tests++;
    if (to || quotient !== 8'hFD || remainder !== 8'hFF) begin
      fails++; $display("FAIL signed_m7_2: got q=%h r=%h (timeout=%b), expected q=fd r=ff",
                        quotient, remainder, to);
    end
    run_div(8'hF9, 8'h02, 2'b00, 1'b0, e, bc, to);
    tests++;
    if (to || quotient !== 8'd124 || remainder !== 8'd1) begin
      fails++; $display("FAIL unsigned_249_2: got q=%h r=%h (timeout=%b), expected q=7c r=01",
                        quotient, remainder, to);
    end
  endtask

  task automatic test_div_zero();
    int e, bc; bit to;
    run_div(8'h55, 8'h00, 2'b00, 1'b0, e, bc, to);
    tests++;
    if (to || e !== 10) begin
      fails++; $display("FAIL dbz_latency: got %0d edges (timeout=%b), expected 10", e, to);
    end
    tests++;
    if (quotient !== 8'hFF || remainder !== 8'h55 || div_by_zero !== 1'b1) begin
      fails++; $display("FAIL dbz_result: got q=%h r=%h dbz=%b, expected q=ff r=55 dbz=1",
                        quotient, remainder, div_by_zero);
    end
    run_div(8'h80, 8'h03, 2'b01, 1'b0, e, bc, to);
    tests++;
    if (to || quotient !== 8'd42 || remainder !== 8'd2 || div_by_zero !== 1'b0) begin
      fails++; $display("FAIL mixed_128_3: got q=%h r=%h dbz=%b, expected q=2a r=02 dbz=0",
                        quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_overflow();
    int e, bc; bit to;
    run_div(8'h80, 8'hFF, 2'b11, 1'b0, e, bc, to);
    tests++;
    if (to || quotient !== 8'h80 || remainder !== 8'h00) begin
      fails++; $display("FAIL overflow_m128_m1: got q=%h r=%h (timeout=%b), expected q=80 r=00",
                        quotient, remainder, to);
    end
  endtask

  task automatic test_back_to_back();
    int e, bc, edges; bit to, seen;
    @(negedge clk);
    dividend = 8'd200; divisor = 8'd3; sign_mode = 2'b00; start = 1'b1;
    @(posedge clk);
    edges = 1;
    seen  = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      start = (n == 3 || n == 5);
      if (start) begin
        dividend = 8'd9; divisor = 8'd4;
      end
      if (n == 5) begin
        tests++;
        if (quotient !== 8'h80 || remainder !== 8'h00) begin
          fails++; $display("FAIL hold_during_calc: got q=%h r=%h, expected q=80 r=00",
                            quotient, remainder);
        end
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      edges++;
    end
    tests++;
    if (!seen || edges !== 10) begin
      fails++; $display("FAIL ignore_start_latency: got %0d edges (done seen=%b), expected 10", edges, seen);
    end
    tests++;
    if (quotient !== 8'd66 || remainder !== 8'd2) begin
      fails++; $display("FAIL ignore_start_200_3: got q=%h r=%h, expected q=42 r=02", quotient, remainder);
    end
    run_div(8'd9, 8'd4, 2'b00, 1'b1, e, bc, to);
    tests++;
    if (to || e !== 10) begin
      fails++; $display("FAIL b2b_latency: got %0d edges (timeout=%b), expected 10", e, to);
    end
    tests++;
    if (quotient !== 8'd2 || remainder !== 8'd1) begin
      fails++; $display("FAIL b2b_9_4: got q=%h r=%h, expected q=02 r=01", quotient, remainder);
    end
  endtask

  task automatic test_mid_reset();
    int e, bc, dones; bit to;
    @(negedge clk);
    dividend = 8'd100; divisor = 8'd7; sign_mode = 2'b00; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if ({quotient, remainder, busy, done, div_by_zero} !== 19'd0) begin
      fails++; $display("FAIL mid_reset_outputs: got q=%h r=%h busy=%b done=%b dbz=%b, expected all 0",
                        quotient, remainder, busy, done, div_by_zero);
    end
    rst_n = 1'b1;
    dones = 0;
    repeat (15) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    tests++;
    if (dones !== 0) begin
      fails++; $display("FAIL mid_reset_no_done: got %0d active cycles, expected 0", dones);
    end
    run_div(8'hF9, 8'h02, 2'b00, 1'b0, e, bc, to);
    tests++;
    if (to || e !== 10 || quotient !== 8'd124 || remainder !== 8'd1) begin
      fails++; $display("FAIL post_reset_divide: got edges=%0d q=%h r=%h, expected edges=10 q=7c r=01",
                        e, quotient, remainder);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
